fifo_1r1w_sync: RTL and testbench

// - Single-clock, one-write/one-read FIFO with ready/valid handshakes on both sides.
// - Sits between a producer and a consumer stage in the same clock domain.
// - Absorbs rate mismatch and backpressure; preserves strict in-order delivery.
// - Registered output: no combinational path from any input to any output.

---
 rtl/fifo_1r1w_sync_if.sv | 49 ++++
 rtl/fifo_1r1w_sync.sv | 153 +++++++++++++++
 tb/tb_fifo_1r1w_sync.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_1r1w_sync_if.sv
// ----------------------------------------------------------------------------
// fifo_1r1w_sync_if
// Groups the write-side and read-side handshake signals of fifo_1r1w_sync.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clock edge when valid and ready are both 1.
//   The sender holds data and valid steady until the transfer happens.
//   The receiver may raise or lower ready at any time.
//
// Signals
//   data_i   write data              (producer -> FIFO)
//   valid_i  producer has data       (producer -> FIFO)
//   ready_o  FIFO can accept         (FIFO -> producer)
//   data_o   head-of-queue data      (FIFO -> consumer)
//   valid_o  data_o holds an entry   (FIFO -> consumer)
//   ready_i  consumer accepts data_o (consumer -> FIFO)
//
// Modports
//   slave  : the FIFO itself
//   master : the environment driving the FIFO (producer + consumer)
// ----------------------------------------------------------------------------
interface fifo_1r1w_sync_if #(
  parameter int width_p = 8
);
  logic [width_p-1:0] data_i;
  logic               valid_i;
  logic               ready_o;
  logic [width_p-1:0] data_o;
  logic               valid_o;
  logic               ready_i;

  modport slave (
    input  data_i,
    input  valid_i,
    input  ready_i,
    output ready_o,
    output data_o,
    output valid_o
  );

  modport master (
    output data_i,
    output valid_i,
    output ready_i,
    input  ready_o,
    input  data_o,
    input  valid_o
  );
endinterface

// File: rtl/fifo_1r1w_sync.sv
// ----------------------------------------------------------------------------
// fifo_1r1w_sync
// Single-clock FIFO with one write port and one read port, ready/valid on
// both sides. Storage is an output (head) register plus a depth_p-entry
// circular buffer, so total capacity is depth_p+1. All outputs come from
// registered state; nothing on the input side reaches an output in the same
// cycle.
//
// Parameters
//   width_p  data width in bits (>=1)
//   depth_p  circular-buffer entries (>=2)
//
// Ports
//   clk_i    clock, all state updates on the rising edge
//   reset_i  synchronous, active-high reset
//   bus      fifo_1r1w_sync_if.slave (data_i/valid_i/ready_o on the write
//            side, data_o/valid_o/ready_i on the read side)
//
// Optional build macro
//   FIFO_1R1W_ASSERT_EN  when defined, adds simulation-only concurrent
//                        assertions on occupancy, flags and output stability.
// ----------------------------------------------------------------------------
module fifo_1r1w_sync #(
  parameter int width_p = 8,
  parameter int depth_p = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  fifo_1r1w_sync_if.slave       bus
);

  localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int cnt_w = $clog2(depth_p + 2);

  localparam logic [ptr_w-1:0] last_ptr_c = ptr_w'(depth_p - 1);
  localparam logic [cnt_w-1:0] full_c     = cnt_w'(depth_p + 1);
  localparam logic [cnt_w-1:0] one_c      = cnt_w'(1);

  // Storage
  logic [width_p-1:0] mem [depth_p];
  logic [width_p-1:0] head_r;
  logic [ptr_w-1:0]   wr_ptr_r;
  logic [ptr_w-1:0]   rd_ptr_r;
  logic [cnt_w-1:0]   count_r;

  // Handshake flags come only from the registered count.
  logic ready_w;
  logic valid_w;
  assign ready_w = (count_r != full_c);
  assign valid_w = (count_r != '0);

  assign bus.ready_o = ready_w;
  assign bus.valid_o = valid_w;
  assign bus.data_o  = head_r;

  logic wr_fire;
  logic rd_fire;
  assign wr_fire = bus.valid_i & ready_w;
  assign rd_fire = valid_w & bus.ready_i;

  // The buffer holds every entry except the one sitting in the head register.
  logic buf_nonempty;
  assign buf_nonempty = (count_r > one_c);

  logic             head_load_in;   // head <= data_i (bypass the buffer)
  logic             head_load_buf;  // head <= buffer entry at rd_ptr
  logic             buf_push;       // buffer[wr_ptr] <= data_i
  logic [cnt_w-1:0] count_next;

  always_comb begin
    head_load_in  = 1'b0;
    head_load_buf = 1'b0;
    buf_push      = 1'b0;
    count_next    = count_r;

    // Head is refilled from the buffer whenever it is read and the buffer
    // has something; otherwise a write goes straight to the head if the head
    // is (or is about to become) free, which also keeps order when count=1
    // and both sides fire.
    if (rd_fire && buf_nonempty) begin
      head_load_buf = 1'b1;
    end

    if (wr_fire) begin
      if (!valid_w || (rd_fire && !buf_nonempty)) begin
        head_load_in = 1'b1;
      end else begin
        buf_push = 1'b1;
      end
    end

    unique case ({wr_fire, rd_fire})
      2'b10:   count_next = count_r + one_c;
      2'b01:   count_next = count_r - one_c;
      default: count_next = count_r;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_r   <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      count_r <= count_next;

      if (head_load_in) begin
        head_r <= bus.data_i;
      end else if (head_load_buf) begin
        head_r <= mem[rd_ptr_r];
      end

      if (head_load_buf) begin
        rd_ptr_r <= (rd_ptr_r == last_ptr_c) ? '0 : rd_ptr_r + 1'b1;
      end

      if (buf_push) begin
        wr_ptr_r <= (wr_ptr_r == last_ptr_c) ? '0 : wr_ptr_r + 1'b1;
      end
    end
  end

  // Buffer contents need no reset: an entry is only read after being written.
  always_ff @(posedge clk_i) begin
    if (buf_push && !reset_i) begin
      mem[wr_ptr_r] <= bus.data_i;
    end
  end

`ifdef FIFO_1R1W_ASSERT_EN
  // Simulation-only checks, inactive while reset is asserted.
  a_count_range: assert property (
    @(posedge clk_i) disable iff (reset_i) count_r <= full_c
  ) else $error("fifo_1r1w_sync: count %0d exceeds capacity", count_r);

  a_ready_full: assert property (
    @(posedge clk_i) disable iff (reset_i) (!bus.ready_o) == (count_r == full_c)
  ) else $error("fifo_1r1w_sync: ready_o disagrees with full state");

  a_valid_empty: assert property (
    @(posedge clk_i) disable iff (reset_i) (!bus.valid_o) == (count_r == '0)
  ) else $error("fifo_1r1w_sync: valid_o disagrees with empty state");

  a_out_stable: assert property (
    @(posedge clk_i) disable iff (reset_i)
      (bus.valid_o && !bus.ready_i) |=> (bus.valid_o && $stable(bus.data_o))
  ) else $error("fifo_1r1w_sync: data_o changed while stalled");
`else
  // Assertions compiled out; function and ports are unchanged.
`endif

endmodule

// File: tb/tb_fifo_1r1w_sync.sv
// ----------------------------------------------------------------------------
// tb_fifo_1r1w_sync
// Self-checking bench for fifo_1r1w_sync (width 8, depth 8, capacity 9).
// The reference model is a plain queue of accepted words: a write is accepted
// when the queue holds fewer than 9 words, a read when it holds at least one.
// Expected outputs follow from the queue after each clock edge:
//   valid_o = queue not empty, ready_o = queue not full, data_o = queue head.
// ----------------------------------------------------------------------------
module tb_fifo_1r1w_sync;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CAP   = DEPTH + 1;

  // Clock / reset
  logic clk_i;
  logic reset_i;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  fifo_1r1w_sync_if #(.width_p(WIDTH)) bus ();

  fifo_1r1w_sync #(
    .width_p(WIDTH),
    .depth_p(DEPTH)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  // Scoreboard
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_v;
  logic             exp_r;
  int               total;
  int               bad;

  // Model outputs derived from the queue.
  task automatic update_exp();
    exp_v = (exp_q.size() != 0);
    exp_r = (exp_q.size() != CAP);
  endtask

  // Driver: apply one cycle of inputs, advance the model, sample #1 after edge.
  task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
    logic wr_f;
    logic rd_f;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    wr_f = v && (exp_q.size() < CAP);
    rd_f = r && (exp_q.size() > 0);
    @(posedge clk_i);
    #1;
    if (rd_f) void'(exp_q.pop_front());
    if (wr_f) exp_q.push_back(d);
    update_exp();
  endtask

  task automatic do_reset(input int n);
    reset_i     = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
    repeat (n) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    exp_q.delete();
    update_exp();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset(10);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: valid_o=%b ready_o=%b data_o=%h, need 0 1 00",
                 i, bus.valid_o, bus.ready_o, bus.data_o);
      end
      drive_cycle(1'b0, 8'hff, 1'b0);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= CAP; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b0);
      total++;
      if (bus.valid_o !== exp_v || bus.ready_o !== exp_r || bus.data_o !== 8'h01) begin
        bad++;
        $display("FAIL fill wr=%0d: valid_o=%b ready_o=%b data_o=%h, need %b %b 01",
                 i, bus.valid_o, bus.ready_o, bus.data_o, exp_v, exp_r);
      end
    end
    // Writes while full are ignored.
    drive_cycle(1'b1, 8'haa, 1'b0);
    total++;
    if (bus.ready_o !== 1'b0 || bus.data_o !== 8'h01 || exp_q.size() != CAP) begin
      bad++;
      $display("FAIL fill_ignore: ready_o=%b data_o=%h, need 0 01", bus.ready_o, bus.data_o);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= CAP; i++) begin
      total++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== 8'(i)) begin
        bad++;
        $display("FAIL drain rd=%0d: valid_o=%b data_o=%h, need 1 %h",
                 i, bus.valid_o, bus.data_o, 8'(i));
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
    // Reading an empty FIFO changes nothing.
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
        bad++;
        $display("FAIL drain_empty cyc=%0d: valid_o=%b ready_o=%b, need 0 1",
                 i, bus.valid_o, bus.ready_o);
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      total++;
      if (exp_q.size() != 4 || bus.valid_o !== 1'b1 || bus.ready_o !== 1'b1 ||
          bus.data_o !== exp_q[0]) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d: valid_o=%b ready_o=%b data_o=%h, need 1 1 %h",
                 i, bus.valid_o, bus.ready_o, bus.data_o, exp_q[0]);
      end
    end
    while (exp_q.size() != 0) drive_cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (bus.valid_o !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_empty: valid_o=%b, need 0", bus.valid_o);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < CAP; i++) drive_cycle(1'b1, 8'(8'h40 + i), 1'b0);
    total++;
    if (bus.ready_o !== 1'b0) begin
      bad++;
      $display("FAIL full_before: ready_o=%b, need 0", bus.ready_o);
    end
    drive_cycle(1'b1, 8'hee, 1'b1);
    total++;
    if (exp_q.size() != DEPTH || bus.ready_o !== 1'b1 || bus.valid_o !== 1'b1 ||
        bus.data_o !== 8'h41) begin
      bad++;
      $display("FAIL full_rw: ready_o=%b valid_o=%b data_o=%h, need 1 1 41",
               bus.ready_o, bus.valid_o, bus.data_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    total++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== '0) begin
      bad++;
      $display("FAIL mid_reset: valid_o=%b ready_o=%b data_o=%h, need 0 1 00",
               bus.valid_o, bus.ready_o, bus.data_o);
    end
    drive_cycle(1'b1, 8'h5c, 1'b0);
    total++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h5c) begin
      bad++;
      $display("FAIL mid_reset_write: valid_o=%b data_o=%h, need 1 5c", bus.valid_o, bus.data_o);
    end
    drive_cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    int guard;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) < 8));
      total++;
      if (bus.valid_o !== exp_v || bus.ready_o !== exp_r ||
          (exp_v && bus.data_o !== exp_q[0])) begin
        bad++;
        $display("FAIL random cyc=%0d: valid_o=%b ready_o=%b data_o=%h, need %b %b %h",
                 i, bus.valid_o, bus.ready_o, bus.data_o, exp_v, exp_r,
                 exp_v ? exp_q[0] : 8'h00);
      end
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      total++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== exp_q[0]) begin
        bad++;
        $display("FAIL random_drain: valid_o=%b data_o=%h, need 1 %h",
                 bus.valid_o, bus.data_o, exp_q[0]);
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    total++;
    if (guard >= 50 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      bad++;
      $display("FAIL random_end: valid_o=%b ready_o=%b guard=%0d, need 0 1", bus.valid_o,
               bus.ready_o, guard);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    reset_i     = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i  = '0;
    update_exp();

    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_rw();
    test_mid_reset();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
